// File: rtl/timer_a_prediv_count_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_a_prediv_count_if : control/status bundle for the timer core    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface timer_a_prediv_count_if;
  logic [1:0]  TASSEL;
  logic [1:0]  ID;
  logic [2:0]  IDEX;
  logic [1:0]  MC;
  logic        TACLR;
  logic [15:0] CCR0;
  logic        TAR_wr;
  logic [15:0] TAR_wdata;
  logic [15:0] TAR;
  logic        tick;
  logic        TAIFG_set;

  modport master (
    output TASSEL, ID, IDEX, MC, TACLR, CCR0, TAR_wr, TAR_wdata,
    input  TAR, tick, TAIFG_set
  );

  modport slave (
    input  TASSEL, ID, IDEX, MC, TACLR, CCR0, TAR_wr, TAR_wdata,
    output TAR, tick, TAIFG_set
  );
endinterface
`default_nettype wire

// File: rtl/timer_a_prediv_count.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_a_prediv_count : source sync, two-stage predivider, 16b counter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module timer_a_prediv_count #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   MCLK,
  input  logic                   reset,
  input  logic                   TACLK,
  input  logic                   ACLK,
  input  logic                   SMCLK,
  input  logic                   INCLK,
  timer_a_prediv_count_if.slave  ta_bus
);

  localparam logic [1:0] c_MC_STOP = 2'b00;
  localparam logic [1:0] c_MC_UP   = 2'b01;
  localparam logic [1:0] c_MC_CONT = 2'b10;
  localparam logic [1:0] c_MC_UPDN = 2'b11;

  logic                   w_src;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_edge_d;
  logic                   r_armed;
  logic                   w_src_edge;

  always_comb begin
    w_src = 1'b0;
    unique case (ta_bus.TASSEL)
      2'b00:   w_src = TACLK;
      2'b01:   w_src = ACLK;
      2'b10:   w_src = SMCLK;
      default: w_src = INCLK;
    endcase
  end

  // r_vld tracks which sync stages hold post-reset samples; a rising edge
  // only counts once a genuine low level has been seen after reset/clear.
  assign w_src_edge = r_armed & r_sync[SYNC_STAGES-1] & ~r_edge_d;

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_sync   <= '0;
      r_vld    <= '0;
      r_edge_d <= 1'b0;
      r_armed  <= 1'b0;
    end else if (ta_bus.TACLR) begin
      r_sync   <= '0;
      r_vld    <= '0;
      r_edge_d <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_sync[0] <= w_src;
      r_vld[0]  <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_edge_d <= r_sync[SYNC_STAGES-1];
      if (r_vld[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) begin
        r_armed <= 1'b1;
      end
    end
  end

  logic [2:0] r_div1;
  logic [2:0] r_div2;
  logic [2:0] w_t1;
  logic       w_t1_hit;
  logic       w_t2_hit;
  logic       r_tick;

  always_comb begin
    w_t1 = 3'd0;
    unique case (ta_bus.ID)
      2'b00:   w_t1 = 3'd0;
      2'b01:   w_t1 = 3'd1;
      2'b10:   w_t1 = 3'd3;
      default: w_t1 = 3'd7;
    endcase
  end

  // >= rather than == so a lowered terminal wraps instead of stalling
  assign w_t1_hit = (r_div1 >= w_t1);
  assign w_t2_hit = (r_div2 >= ta_bus.IDEX);

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_div1 <= 3'd0;
      r_div2 <= 3'd0;
      r_tick <= 1'b0;
    end else if (ta_bus.TACLR) begin
      r_div1 <= 3'd0;
      r_div2 <= 3'd0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_src_edge) begin
        if (w_t1_hit) begin
          r_div1 <= 3'd0;
          if (w_t2_hit) begin
            r_div2 <= 3'd0;
            r_tick <= 1'b1;
          end else begin
            r_div2 <= r_div2 + 3'd1;
          end
        end else begin
          r_div1 <= r_div1 + 3'd1;
        end
      end
    end
  end

  logic [15:0] r_tar;
  logic        r_dir;
  logic        r_taifg;
  logic [1:0]  r_mc_q;
  logic        w_dir;

  // Entering up/down from any other mode restarts the count direction upward.
  assign w_dir = ((ta_bus.MC == c_MC_UPDN) && (r_mc_q != c_MC_UPDN)) ? 1'b0 : r_dir;

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_tar   <= 16'h0000;
      r_dir   <= 1'b0;
      r_taifg <= 1'b0;
      r_mc_q  <= c_MC_STOP;
    end else if (ta_bus.TACLR) begin
      r_tar   <= 16'h0000;
      r_dir   <= 1'b0;
      r_taifg <= 1'b0;
      r_mc_q  <= ta_bus.MC;
    end else begin
      r_taifg <= 1'b0;
      r_mc_q  <= ta_bus.MC;
      r_dir   <= w_dir;
      if (ta_bus.TAR_wr) begin
        r_tar <= ta_bus.TAR_wdata;
      end else if (r_tick) begin
        unique case (ta_bus.MC)
          c_MC_STOP: r_tar <= r_tar;
          c_MC_CONT: begin
            r_tar   <= r_tar + 16'd1;
            r_taifg <= (r_tar == 16'hFFFF);
          end
          c_MC_UP: begin
            if (ta_bus.CCR0 == 16'h0000) begin
              r_tar <= 16'h0000;
            end else if (r_tar >= ta_bus.CCR0) begin
              r_tar   <= 16'h0000;
              r_taifg <= 1'b1;
            end else begin
              r_tar <= r_tar + 16'd1;
            end
          end
          default: begin
            if (ta_bus.CCR0 == 16'h0000) begin
              r_tar <= 16'h0000;
            end else if (!w_dir) begin
              if (r_tar >= ta_bus.CCR0) begin
                r_tar <= r_tar - 16'd1;
                r_dir <= 1'b1;
              end else begin
                r_tar <= r_tar + 16'd1;
              end
            end else begin
              if (r_tar == 16'h0001) begin
                r_tar   <= 16'h0000;
                r_taifg <= 1'b1;
                r_dir   <= 1'b0;
              end else if (r_tar == 16'h0000) begin
                r_tar <= 16'h0001;
                r_dir <= 1'b0;
              end else begin
                r_tar <= r_tar - 16'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign ta_bus.TAR       = r_tar;
  assign ta_bus.tick      = r_tick;
  assign ta_bus.TAIFG_set = r_taifg;

endmodule
`default_nettype wire

// File: tb/tb_timer_a_prediv_count.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_timer_a_prediv_count : directed scoreboard bench for the timer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_timer_a_prediv_count;

  logic MCLK = 1'b0;
  logic reset;
  logic TACLK;
  logic ACLK;
  logic SMCLK;
  logic INCLK;

  timer_a_prediv_count_if bus ();

  timer_a_prediv_count #(.SYNC_STAGES(2)) dut (
    .MCLK   (MCLK),
    .reset  (reset),
    .TACLK  (TACLK),
    .ACLK   (ACLK),
    .SMCLK  (SMCLK),
    .INCLK  (INCLK),
    .ta_bus (bus)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic [15:0] tar;
    logic        ifg;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_tick = 0;
  int gap = 0;
  int n_double = 0;
  int n_flag = 0;
  int n_tick = 0;
  int inclk_rises = 0;
  int f0;
  int t0;
  int r0;
  bit chk_en = 1'b0;
  bit prev_tick = 1'b0;
  bit prev_flag = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] tar, input logic ifg);
    exp_t e;
    e.tar = tar;
    e.ifg = ifg;
    q.push_back(e);
  endtask

  // One MCLK cycle: sample at negedge, score TAR after each tick, then move sources.
  task automatic step();
    exp_t e;
    @(negedge MCLK);
    cyc++;
    if (chk_en && prev_tick && (q.size() != 0)) begin
      e = q.pop_front();
      check("sb_tar", {16'h0, bus.TAR}, {16'h0, e.tar});
      check("sb_taifg", {31'h0, bus.TAIFG_set}, {31'h0, e.ifg});
    end
    if (bus.tick === 1'b1) begin
      if (prev_tick) n_double++;
      gap = cyc - last_tick;
      last_tick = cyc;
      n_tick++;
    end
    if (bus.TAIFG_set === 1'b1) begin
      if (prev_flag) n_double++;
      n_flag++;
    end
    prev_tick = (bus.tick === 1'b1);
    prev_flag = (bus.TAIFG_set === 1'b1);
    TACLK = ~TACLK;
    if (cyc % 2 == 0) SMCLK = ~SMCLK;
    if (cyc % 3 == 0) ACLK = ~ACLK;
    if (cyc % 4 == 0) begin
      INCLK = ~INCLK;
      if (INCLK) inclk_rises++;
    end
  endtask

  task automatic load(input logic [15:0] v);
    bus.TAR_wr = 1'b1;
    bus.TAR_wdata = v;
    chk_en = 1'b0;
    step();
    bus.TAR_wr = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_q(input int bound, input string tag);
    for (int i = 0; i < bound && q.size() != 0; i++) step();
    check(tag, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    TACLK = 1'b0; ACLK = 1'b0; SMCLK = 1'b0; INCLK = 1'b0;
    bus.TASSEL = 2'b10; bus.ID = 2'b00; bus.IDEX = 3'd0; bus.MC = 2'b00;
    bus.TACLR = 1'b0; bus.CCR0 = 16'h0000; bus.TAR_wr = 1'b0; bus.TAR_wdata = 16'h0000;
    #1 reset = 1'b0;
    #2;
    check("rst_tar", {16'h0, bus.TAR}, 0);
    check("rst_tick", {31'h0, bus.tick}, 0);
    check("rst_taifg", {31'h0, bus.TAIFG_set}, 0);
    repeat (3) step();
    reset = 1'b1;

    // continuous wrap FFFE -> FFFF -> 0000 (flag) -> 0001
    bus.MC = 2'b10;
    load(16'hFFFE);
    check("ld_fffe", {16'h0, bus.TAR}, 32'hFFFE);
    f0 = n_flag;
    push(16'hFFFF, 1'b0); push(16'h0000, 1'b1); push(16'h0001, 1'b0);
    wait_q(100, "cont_drain");
    check("cont_flag_cnt", n_flag - f0, 1);

    // divide by 8*3 = 24 source edges; SMCLK edge every 4 MCLK
    bus.ID = 2'b11; bus.IDEX = 3'd2;
    load(16'h0100);
    push(16'h0101, 1'b0); push(16'h0102, 1'b0); push(16'h0103, 1'b0);
    wait_q(400, "div24_drain");
    check("div24_gap", gap, 96);

    // up mode, CCR0 = 3
    bus.ID = 2'b00; bus.IDEX = 3'd0; bus.MC = 2'b01; bus.CCR0 = 16'h0003;
    load(16'h0000);
    for (int k = 0; k < 2; k++) begin
      push(16'h0001, 1'b0); push(16'h0002, 1'b0); push(16'h0003, 1'b0); push(16'h0000, 1'b1);
    end
    wait_q(100, "up_drain");
    bus.CCR0 = 16'h0000;
    f0 = n_flag;
    push(16'h0000, 1'b0); push(16'h0000, 1'b0); push(16'h0000, 1'b0);
    wait_q(60, "up0_drain");
    check("up0_no_flag", n_flag - f0, 0);

    // up/down mode, CCR0 = 2
    bus.MC = 2'b11; bus.CCR0 = 16'h0002;
    load(16'h0000);
    for (int k = 0; k < 2; k++) begin
      push(16'h0001, 1'b0); push(16'h0002, 1'b0); push(16'h0001, 1'b0); push(16'h0000, 1'b1);
    end
    wait_q(100, "updn_drain");

    // TACLR and TAR_wr coincident with a tick at TAR = 1234h
    bus.MC = 2'b00;
    load(16'h1234);
    step();
    check("ld_1234", {16'h0, bus.TAR}, 32'h1234);
    bus.MC = 2'b10;
    for (int i = 0; i < 20 && bus.tick !== 1'b1; i++) step();
    check("clr_tick_seen", {31'h0, bus.tick}, 1);
    bus.TACLR = 1'b1; bus.TAR_wr = 1'b1; bus.TAR_wdata = 16'hABCD; chk_en = 1'b0;
    step();
    check("clr_tar", {16'h0, bus.TAR}, 0);
    check("clr_tick", {31'h0, bus.tick}, 0);
    check("clr_taifg", {31'h0, bus.TAIFG_set}, 0);
    t0 = n_tick;
    repeat (10) step();
    check("clr_no_ticks", n_tick - t0, 0);
    bus.TACLR = 1'b0; bus.TAR_wr = 1'b0; chk_en = 1'b1;

    // async reset mid-count, then fresh edges needed after release
    bus.TASSEL = 2'b11; bus.ID = 2'b01; bus.IDEX = 3'd1;
    for (int i = 0; i < 100 && bus.tick !== 1'b1; i++) step();
    load(16'h0055);
    repeat (12) step();
    check("pre_rst_tar", {16'h0, bus.TAR}, 32'h0055);
    #2 reset = 1'b0;
    #1;
    check("arst_tar", {16'h0, bus.TAR}, 0);
    check("arst_tick", {31'h0, bus.tick}, 0);
    check("arst_taifg", {31'h0, bus.TAIFG_set}, 0);
    repeat (2) step();
    for (int i = 0; i < 20 && INCLK !== 1'b1; i++) step();
    reset = 1'b1;
    r0 = inclk_rises;
    push(16'h0001, 1'b0);
    for (int i = 0; i < 200 && bus.tick !== 1'b1; i++) step();
    check("rst_first_tick_edges", inclk_rises - r0, 4);
    wait_q(20, "rst_drain");

    check("no_double_pulse", n_double, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
